hsi_frame_rx: RTL and testbench
===============================

Name: hsi_frame_rx

Overview:
- Far-end receiver for the HSI downlink driven by the tester's bidirectional wrapper.
- Recovers serial words from the HSI_DAP/HSI_DBP lanes, using HS_Clock as the bit strobe and SYNCK as the frame marker. Both are oversampled by clk.
- Emits recovered words on an AXI-stream producer toward the loopback/check FIFO.
- Used in the funcsim bench as the DUT-side model, and for tester self-loopback.

Parameters:
- WORD_BITS, 32: bits per word. Must be even; lane A carries the upper half, lane B the lower half.
- FRAME_WORDS, 8: words per SYNCK frame. TLAST is on the last word.
- FIFO_DEPTH, 4: output buffer depth in words. Power of 2, ≥2.

Ports:
- clk  in  1  system clock; must be ≥4x the HS_Clock frequency.
- rst  in  1  synchronous, active-high reset.
- HS_Clock  in  1  asynchronous bit strobe; data is sampled on its rising edge.
- SYNCK  in  1  asynchronous frame-start marker, valid at HS_Clock rise.
- HSI_DAP  in  1  lane A serial data, MSB first.
- HSI_DBP  in  1  lane B serial data, MSB first.
- m_axis_tdata  out  WORD_BITS  recovered word {laneA[WORD_BITS/2-1:0], laneB[WORD_BITS/2-1:0]}.
- m_axis_tvalid  out  1  word available.
- m_axis_tready  in  1  consumer ready.
- m_axis_tlast  out  1  last word of frame.
- clr_flags  in  1  pulse; clears the sticky flags.
- ovf_sticky  out  1  a word was dropped because the FIFO was full.
- sync_err_sticky  out  1  SYNCK arrived mid-word or mid-frame.
- word_cnt  out  16  count of words written to the FIFO; wraps 0xFFFF→0.

Behaviour:
- Synchronisation and sampling:
  - HS_Clock, SYNCK, HSI_DAP and HSI_DBP each pass through an identical 2-flop synchroniser.
  - rise = hs_s2 & ~hs_s3.
  - All sampling occurs only in cycles where rise=1. Other cycles hold state.
- Reset (rst=1 at a clk edge):
  - FSM returns to IDLE; bit_cnt, word_idx, shift regs, FIFO pointers, flags and word_cnt clear.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, ovf_sticky=0, sync_err_sticky=0, word_cnt=0.
  - Reset mid-frame discards the partial word and all buffered words.
- FSM states:
  - IDLE: ignore lanes. On rise with SYNCK=1, capture bit MSB of word 0, set bit_cnt=1, word_idx=0, go to SHIFT.
  - SHIFT: on rise, shift in one bit per lane and increment bit_cnt. When bit_cnt reaches WORD_BITS/2, the word is complete:
    - push the word with tlast = (word_idx==FRAME_WORDS-1);
    - bit_cnt=0, word_idx++;
    - if that was the last word, go to IDLE; otherwise stay in SHIFT (continuous, no SYNCK needed).
  - SYNCK in SHIFT with bit_cnt≠0: discard the partial word, set sync_err_sticky, restart as a new frame. The current bit becomes MSB of word 0; bit_cnt=1, word_idx=0.
  - SYNCK in SHIFT with bit_cnt==0 and word_idx≠0: set sync_err_sticky, restart the frame at word 0. Already-pushed words are kept; none of them carries tlast.
- Latency:
  - The FIFO write occurs in the clk cycle after the rise cycle that captured the final bit.
  - m_axis_tvalid rises the following cycle when the FIFO was empty.
  - Total latency is 2 clk from the final-bit rise cycle (4 clk from the final-bit HS_Clock edge at the pin).
- FIFO:
  - Output is first-word-fall-through: tdata/tlast are stable while tvalid=1 and tready=0.
  - Pop occurs on tvalid&tready.
  - Simultaneous push and pop when full: the push is accepted.
  - Push when full and no pop: the word is dropped, ovf_sticky is set, word_cnt is unchanged, and FSM progress continues normally.
- word_cnt increments once per accepted push.
- Flags:
  - clr_flags clears both stickies.
  - If clr_flags coincides with a set event, the set wins.
- tready never stalls the serial side; backpressure is absorbed only by the FIFO, with overflow handling as above.

Test Plan:
- Clean frame: WORD_BITS=32, FRAME_WORDS=8, SYNCK on the first bit. Lane A sends 0x1234,0x0001..0x0007 and lane B sends 0xABCD,0x0000.. with tready=1.
  - Required: 8 words, first 0x1234ABCD; tlast only on word 7; word_cnt=8; flags 0; tvalid exactly 2 clk after the final-bit rise cycle.
- Backpressure:
  - Hold tready=0 through a full 8-word frame with FIFO_DEPTH=4 → 4 words buffered; words 4–7 dropped; ovf_sticky=1; word_cnt=4.
  - Then tready=1 → words 0–3 delivered in order, none with tlast.
- Mid-word resync: SYNCK asserted at bit 9 of word 2.
  - Required: words 0–1 delivered, partial word 2 discarded, sync_err_sticky=1.
  - The new frame's word 0 is assembled from the bit-9 data onward; a full frame of 8 follows with tlast on its 8th word.
- Back-to-back frames: two frames with no gap, SYNCK on each first bit → 16 words, tlast on words 7 and 15, no error.
- Reset mid-frame: assert rst for 1 clk after 3 words with 2 unread in the FIFO.
  - Required: tvalid=0, word_cnt=0 next cycle; lane activity is ignored until the next SYNCK.
- Flag clear: clr_flags pulses while ovf_sticky=1 and sync_err_sticky=1 → both 0 next cycle. A coincident overflow event keeps ovf_sticky=1.

Source files
------------

// File: rtl/hsi_frame_rx.sv
// HSI downlink far-end receiver: oversamples the HS_Clock/SYNCK/lane pins, rebuilds
// WORD_BITS-wide words from two MSB-first lanes and streams them out through a small FWFT FIFO.
module hsi_frame_rx #(
    parameter int WORD_BITS   = 32,
    parameter int FRAME_WORDS = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 HS_Clock,
    input  logic                 SYNCK,
    input  logic                 HSI_DAP,
    input  logic                 HSI_DBP,
    output logic [WORD_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    input  logic                 clr_flags,
    output logic                 ovf_sticky,
    output logic                 sync_err_sticky,
    output logic [15:0]          word_cnt
);

    localparam int HALF  = WORD_BITS / 2;
    localparam int CW    = $clog2(HALF + 1);
    localparam int IW    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LASTI = FRAME_WORDS - 1;

    localparam logic [CW-1:0] HALF_C   = HALF[CW-1:0];
    localparam logic [IW-1:0] LAST_IDX = LASTI[IW-1:0];
    localparam logic [AW:0]   DEPTH_C  = FIFO_DEPTH[AW:0];

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Pin synchronisers; the strobe gets a third stage for edge detection.
    logic hs_meta_r, hs_sync_r, hs_dly_r;
    logic sy_meta_r, sy_sync_r;
    logic a_meta_r, a_sync_r;
    logic b_meta_r, b_sync_r;
    logic rise_s;

    // Two-flop synchronisers for all four asynchronous pins
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_meta_r <= 1'b0;
            hs_sync_r <= 1'b0;
            hs_dly_r  <= 1'b0;
            sy_meta_r <= 1'b0;
            sy_sync_r <= 1'b0;
            a_meta_r  <= 1'b0;
            a_sync_r  <= 1'b0;
            b_meta_r  <= 1'b0;
            b_sync_r  <= 1'b0;
        end else begin
            hs_meta_r <= HS_Clock;
            hs_sync_r <= hs_meta_r;
            hs_dly_r  <= hs_sync_r;
            sy_meta_r <= SYNCK;
            sy_sync_r <= sy_meta_r;
            a_meta_r  <= HSI_DAP;
            a_sync_r  <= a_meta_r;
            b_meta_r  <= HSI_DBP;
            b_sync_r  <= b_meta_r;
        end
    end

    assign rise_s = hs_sync_r & ~hs_dly_r;

    state_t               state_r;
    logic [CW-1:0]        bit_cnt_r;
    logic [IW-1:0]        word_idx_r;
    logic [HALF-1:0]      sh_a_r, sh_b_r;
    logic                 push_valid_r;
    logic [WORD_BITS-1:0] push_data_r;
    logic                 push_last_r;

    logic [HALF-1:0] new_a_s, new_b_s;
    logic            start_s, adv_s, resync_err_s, word_done_s;
    logic [IW-1:0]   cur_idx_s;
    logic [CW-1:0]   nxt_cnt_s;

    // Decode what the current strobe rise does to the frame state
    always_comb begin
        new_a_s      = HALF'({sh_a_r, a_sync_r});
        new_b_s      = HALF'({sh_b_r, b_sync_r});
        start_s      = 1'b0;
        adv_s        = 1'b0;
        resync_err_s = 1'b0;
        if (rise_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (sy_sync_r) begin
                        start_s = 1'b1;
                    end else begin
                        start_s = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // SYNCK inside a frame always restarts; only a clean word-0 boundary is legal.
                    if (sy_sync_r) begin
                        start_s      = 1'b1;
                        resync_err_s = (bit_cnt_r != {CW{1'b0}}) || (word_idx_r != {IW{1'b0}});
                    end else begin
                        adv_s = 1'b1;
                    end
                end
                default: begin
                    start_s = 1'b0;
                end
            endcase
        end else begin
            start_s = 1'b0;
        end
        cur_idx_s   = start_s ? {IW{1'b0}} : word_idx_r;
        nxt_cnt_s   = start_s ? CW'(1'b1) : (bit_cnt_r + CW'(1'b1));
        word_done_s = (start_s | adv_s) && (nxt_cnt_s == HALF_C);
    end

    // Frame FSM: shifts lanes on each rise and stages completed words for the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= {CW{1'b0}};
            word_idx_r   <= {IW{1'b0}};
            sh_a_r       <= {HALF{1'b0}};
            sh_b_r       <= {HALF{1'b0}};
            push_valid_r <= 1'b0;
            push_data_r  <= {WORD_BITS{1'b0}};
            push_last_r  <= 1'b0;
        end else begin
            push_valid_r <= 1'b0;
            if (start_s | adv_s) begin
                sh_a_r <= new_a_s;
                sh_b_r <= new_b_s;
                if (word_done_s) begin
                    push_valid_r <= 1'b1;
                    push_data_r  <= {new_a_s, new_b_s};
                    push_last_r  <= (cur_idx_s == LAST_IDX);
                    bit_cnt_r    <= {CW{1'b0}};
                    if (cur_idx_s == LAST_IDX) begin
                        word_idx_r <= {IW{1'b0}};
                        state_r    <= ST_IDLE;
                    end else begin
                        word_idx_r <= cur_idx_s + IW'(1'b1);
                        state_r    <= ST_SHIFT;
                    end
                end else begin
                    bit_cnt_r  <= nxt_cnt_s;
                    word_idx_r <= cur_idx_s;
                    state_r    <= ST_SHIFT;
                end
            end
        end
    end

    logic [WORD_BITS:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [AW:0]        count_r;
    logic [15:0]        word_cnt_r;
    logic               ovf_r, sync_err_r;
    logic               full_s, pop_s, push_ok_s, drop_s;

    // A pop frees the head slot in the same edge, so a full FIFO still takes the push.
    always_comb begin
        full_s    = (count_r == DEPTH_C);
        pop_s     = (count_r != {(AW+1){1'b0}}) && m_axis_tready;
        push_ok_s = push_valid_r && (!full_s || pop_s);
        drop_s    = push_valid_r && full_s && !pop_s;
    end

    // FWFT storage, pointers, occupancy and accepted-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {(WORD_BITS+1){1'b0}};
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            word_cnt_r <= 16'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= {push_last_r, push_data_r};
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
                word_cnt_r      <= word_cnt_r + 16'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flags; a set event in the same cycle beats clr_flags
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r      <= 1'b0;
            sync_err_r <= 1'b0;
        end else begin
            ovf_r      <= drop_s | (ovf_r & ~clr_flags);
            sync_err_r <= resync_err_s | (sync_err_r & ~clr_flags);
        end
    end

    assign m_axis_tvalid   = (count_r != {(AW+1){1'b0}});
    assign m_axis_tdata    = mem_r[rd_ptr_r][WORD_BITS-1:0];
    assign m_axis_tlast    = mem_r[rd_ptr_r][WORD_BITS];
    assign ovf_sticky      = ovf_r;
    assign sync_err_sticky = sync_err_r;
    assign word_cnt        = word_cnt_r;

endmodule

// File: tb/tb_hsi_frame_rx.sv
// Directed bench for hsi_frame_rx: bit-level pin stimulus, popped words logged at negedge,
// each scenario task compares against hand-computed words.
module tb_hsi_frame_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        HS_Clock = 1'b0;
    logic        SYNCK = 1'b0;
    logic        HSI_DAP = 1'b0;
    logic        HSI_DBP = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        clr_flags = 1'b0;
    logic        ovf_sticky;
    logic        sync_err_sticky;
    logic [15:0] word_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rise = 0;

    logic [31:0] q_data[$];
    logic        q_last[$];
    int          q_cyc[$];

    hsi_frame_rx #(.WORD_BITS(32), .FRAME_WORDS(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .HS_Clock(HS_Clock), .SYNCK(SYNCK),
        .HSI_DAP(HSI_DAP), .HSI_DBP(HSI_DBP),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .clr_flags(clr_flags), .ovf_sticky(ovf_sticky),
        .sync_err_sticky(sync_err_sticky), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata);
            q_last.push_back(m_axis_tlast);
            q_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bit: 4 clk low with data set up, then 4 clk high; optional clr_flags pulse on the push edge.
    task automatic send_bit(input logic a, input logic b, input logic sy, input logic clr);
        HS_Clock = 1'b0; HSI_DAP = a; HSI_DBP = b; SYNCK = sy;
        tick(4);
        HS_Clock = 1'b1;
        last_rise = cyc;
        if (clr) begin
            tick(3); clr_flags = 1'b1; tick(1); clr_flags = 1'b0;
        end else begin
            tick(4);
        end
    endtask

    task automatic send_word(input logic [15:0] a, input logic [15:0] b, input logic sy, input logic clr_last);
        for (int i = 15; i >= 0; i--) begin
            send_bit(a[i], b[i], sy && (i == 15), clr_last && (i == 0));
        end
    endtask

    task automatic send_idle(input int n);
        HS_Clock = 1'b0; SYNCK = 1'b0;
        tick(n);
    endtask

    task automatic do_reset();
        HS_Clock = 1'b0; SYNCK = 1'b0; HSI_DAP = 1'b0; HSI_DBP = 1'b0; clr_flags = 1'b0;
        tick(3);
        rst = 1'b1; tick(2); rst = 1'b0; tick(2);
        q_data.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic test_reset();
        tick(4);
        rst = 1'b0;
        tick(1);
        checks += 5;
        if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%0b exp=0", m_axis_tvalid); end
        if (m_axis_tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
        if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%0b exp=0", m_axis_tlast); end
        if ({ovf_sticky, sync_err_sticky} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {ovf_sticky, sync_err_sticky}); end
        if (word_cnt !== 16'd0) begin failures++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
    endtask

    task automatic test_clean_frame();
        int lat0;
        logic [31:0] exp;
        do_reset();
        m_axis_tready = 1'b1;
        lat0 = 0;
        for (int w = 0; w < 8; w++) begin
            send_word((w == 0) ? 16'h1234 : 16'(w), (w == 0) ? 16'hABCD : 16'h0000, w == 0, 1'b0);
            if (w == 0) lat0 = last_rise;
        end
        send_idle(8);
        checks++;
        if (q_data.size() != 8) begin failures++; $display("FAIL clean_count got=%0d exp=8", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 8; i++) begin
            exp = (i == 0) ? 32'h1234ABCD : {16'(i), 16'h0000};
            checks += 2;
            if (q_data[i] !== exp) begin failures++; $display("FAIL clean_data[%0d] got=%h exp=%h", i, q_data[i], exp); end
            if (q_last[i] !== (i == 7)) begin failures++; $display("FAIL clean_tlast[%0d] got=%0b exp=%0b", i, q_last[i], i == 7); end
        end
        checks += 3;
        if (word_cnt !== 16'd8) begin failures++; $display("FAIL clean_word_cnt got=%0d exp=8", word_cnt); end
        if ({ovf_sticky, sync_err_sticky} !== 2'b00) begin failures++; $display("FAIL clean_flags got=%b exp=00", {ovf_sticky, sync_err_sticky}); end
        if (q_cyc.size() == 0) begin
            failures++; $display("FAIL clean_latency got=no_word exp=%0d", lat0 + 4);
        end else if (q_cyc[0] != lat0 + 4) begin
            failures++; $display("FAIL clean_latency got=%0d exp=%0d", q_cyc[0], lat0 + 4);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        do_reset();
        m_axis_tready = 1'b0;
        for (int w = 0; w < 8; w++) send_word(16'h0100 + 16'(w), 16'h0200 + 16'(w), w == 0, 1'b0);
        send_idle(8);
        checks += 5;
        if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid got=%0b exp=1", m_axis_tvalid); end
        if (m_axis_tdata !== 32'h01000200) begin failures++; $display("FAIL bp_held_data got=%h exp=01000200", m_axis_tdata); end
        if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL bp_ovf got=%0b exp=1", ovf_sticky); end
        if (sync_err_sticky !== 1'b0) begin failures++; $display("FAIL bp_sync_err got=%0b exp=0", sync_err_sticky); end
        if (word_cnt !== 16'd4) begin failures++; $display("FAIL bp_word_cnt got=%0d exp=4", word_cnt); end
        m_axis_tready = 1'b1;
        tick(10);
        checks += 2;
        if (q_data.size() != 4) begin failures++; $display("FAIL bp_drain_count got=%0d exp=4", q_data.size()); end
        if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL bp_drain_tvalid got=%0b exp=0", m_axis_tvalid); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            exp = {16'h0100 + 16'(i), 16'h0200 + 16'(i)};
            checks += 2;
            if (q_data[i] !== exp) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, q_data[i], exp); end
            if (q_last[i] !== 1'b0) begin failures++; $display("FAIL bp_tlast[%0d] got=%0b exp=0", i, q_last[i]); end
        end
    endtask

    task automatic test_resync();
        logic [31:0] exp;
        do_reset();
        m_axis_tready = 1'b1;
        send_word(16'h0A00, 16'h0B00, 1'b1, 1'b0);
        send_word(16'h0A01, 16'h0B01, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 8; w++) send_word(16'h0C00 + 16'(w), 16'h0D00 + 16'(w), w == 0, 1'b0);
        send_idle(8);
        checks += 4;
        if (q_data.size() != 10) begin failures++; $display("FAIL resync_count got=%0d exp=10", q_data.size()); end
        if (sync_err_sticky !== 1'b1) begin failures++; $display("FAIL resync_err got=%0b exp=1", sync_err_sticky); end
        if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL resync_ovf got=%0b exp=0", ovf_sticky); end
        if (word_cnt !== 16'd10) begin failures++; $display("FAIL resync_word_cnt got=%0d exp=10", word_cnt); end
        for (int i = 0; i < q_data.size() && i < 10; i++) begin
            exp = (i < 2) ? {16'h0A00 + 16'(i), 16'h0B00 + 16'(i)} : {16'h0C00 + 16'(i - 2), 16'h0D00 + 16'(i - 2)};
            checks += 2;
            if (q_data[i] !== exp) begin failures++; $display("FAIL resync_data[%0d] got=%h exp=%h", i, q_data[i], exp); end
            if (q_last[i] !== (i == 9)) begin failures++; $display("FAIL resync_tlast[%0d] got=%0b exp=%0b", i, q_last[i], i == 9); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        do_reset();
        m_axis_tready = 1'b1;
        for (int k = 0; k < 16; k++) send_word(16'h2000 + 16'(k), 16'h3000 + 16'(k), (k % 8) == 0, 1'b0);
        send_idle(8);
        checks += 3;
        if (q_data.size() != 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", q_data.size()); end
        if (sync_err_sticky !== 1'b0) begin failures++; $display("FAIL b2b_sync_err got=%0b exp=0", sync_err_sticky); end
        if (word_cnt !== 16'd16) begin failures++; $display("FAIL b2b_word_cnt got=%0d exp=16", word_cnt); end
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            exp = {16'h2000 + 16'(i), 16'h3000 + 16'(i)};
            checks += 2;
            if (q_data[i] !== exp) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, q_data[i], exp); end
            if (q_last[i] !== (i == 7 || i == 15)) begin failures++; $display("FAIL b2b_tlast[%0d] got=%0b exp=%0b", i, q_last[i], i == 7 || i == 15); end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        m_axis_tready = 1'b0;
        for (int w = 0; w < 3; w++) send_word(16'h4000 + 16'(w), 16'h5000 + 16'(w), w == 0, 1'b0);
        m_axis_tready = 1'b1; tick(1); m_axis_tready = 1'b0;
        checks += 3;
        if (q_data.size() != 1) begin failures++; $display("FAIL rmf_pre_count got=%0d exp=1", q_data.size()); end
        if (word_cnt !== 16'd3) begin failures++; $display("FAIL rmf_pre_word_cnt got=%0d exp=3", word_cnt); end
        if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL rmf_pre_tvalid got=%0b exp=1", m_axis_tvalid); end
        rst = 1'b1; tick(1); rst = 1'b0;
        checks += 2;
        if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rmf_tvalid got=%0b exp=0", m_axis_tvalid); end
        if (word_cnt !== 16'd0) begin failures++; $display("FAIL rmf_word_cnt got=%0d exp=0", word_cnt); end
        m_axis_tready = 1'b1;
        send_word(16'hFFFF, 16'h1111, 1'b0, 1'b0);
        send_word(16'h2222, 16'h3333, 1'b0, 1'b0);
        send_idle(8);
        checks += 2;
        if (q_data.size() != 1) begin failures++; $display("FAIL rmf_ignored_count got=%0d exp=1", q_data.size()); end
        if (word_cnt !== 16'd0) begin failures++; $display("FAIL rmf_ignored_word_cnt got=%0d exp=0", word_cnt); end
        for (int w = 0; w < 8; w++) send_word(16'h6000 + 16'(w), 16'h7000 + 16'(w), w == 0, 1'b0);
        send_idle(8);
        checks += 2;
        if (word_cnt !== 16'd8) begin failures++; $display("FAIL rmf_new_word_cnt got=%0d exp=8", word_cnt); end
        if (q_data.size() != 9) begin
            failures++; $display("FAIL rmf_new_count got=%0d exp=9", q_data.size());
        end else begin
            checks += 3;
            if (q_data[0] !== 32'h40005000) begin failures++; $display("FAIL rmf_popped_data got=%h exp=40005000", q_data[0]); end
            if (q_data[1] !== 32'h60007000) begin failures++; $display("FAIL rmf_new_first got=%h exp=60007000", q_data[1]); end
            if (q_last[8] !== 1'b1) begin failures++; $display("FAIL rmf_new_tlast got=%0b exp=1", q_last[8]); end
        end
    endtask

    task automatic test_flag_clear();
        do_reset();
        m_axis_tready = 1'b0;
        for (int w = 0; w < 4; w++) send_word(16'h8000 + 16'(w), 16'h0000, w == 0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        send_word(16'h9000, 16'h0000, 1'b1, 1'b0);
        tick(4);
        checks += 3;
        if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL flag_ovf_set got=%0b exp=1", ovf_sticky); end
        if (sync_err_sticky !== 1'b1) begin failures++; $display("FAIL flag_sync_set got=%0b exp=1", sync_err_sticky); end
        if (word_cnt !== 16'd4) begin failures++; $display("FAIL flag_word_cnt got=%0d exp=4", word_cnt); end
        clr_flags = 1'b1; tick(1); clr_flags = 1'b0;
        checks += 1;
        if ({ovf_sticky, sync_err_sticky} !== 2'b00) begin failures++; $display("FAIL flag_clear got=%b exp=00", {ovf_sticky, sync_err_sticky}); end
        send_word(16'h9001, 16'h0000, 1'b0, 1'b1);
        checks += 2;
        if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL flag_set_wins got=%0b exp=1", ovf_sticky); end
        if (sync_err_sticky !== 1'b0) begin failures++; $display("FAIL flag_sync_cleared got=%0b exp=0", sync_err_sticky); end
        m_axis_tready = 1'b1;
        send_idle(10);
        checks += 1;
        if (q_data.size() != 4) begin
            failures++; $display("FAIL flag_drain_count got=%0d exp=4", q_data.size());
        end else begin
            checks += 1;
            if (q_data[0] !== 32'h80000000) begin failures++; $display("FAIL flag_drain_first got=%h exp=80000000", q_data[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_backpressure();
        test_resync();
        test_back_to_back();
        test_reset_midframe();
        test_flag_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
